// File: rtl/n64_cfg_mailbox_pkg.sv
// Shared register map and bit positions for the N64 config mailbox.
package n64_cfg_mailbox_pkg;

    // Fixed halfword register indices; data registers follow from REG_DATA_BASE.
    typedef enum logic [2:0] {
        REG_STATUS    = 3'd0,
        REG_COMMAND   = 3'd1,
        REG_CONTROL   = 3'd2,
        REG_VERSION_H = 3'd3,
        REG_VERSION_L = 3'd4
    } e_reg;

    // DATA_k_H at REG_DATA_BASE+2k, DATA_k_L at REG_DATA_BASE+2k+1.
    localparam int REG_DATA_BASE = 5;

    // STATUS bit positions.
    localparam int ST_PENDING  = 15;
    localparam int ST_ERROR    = 14;
    localparam int ST_OVERRUN  = 13;
    localparam int ST_TIMEOUT  = 12;
    localparam int ST_IRQ_PEND = 11;
    localparam int ST_IRQ_EN   = 10;

    // CONTROL bit positions.
    localparam int CTL_IRQ_EN  = 0;
    localparam int CTL_CLR_OVR = 1;
    localparam int CTL_ACK_IRQ = 2;

endpackage

// File: rtl/n64_cfg_mailbox_if.sv
// N64-side halfword register bus.
interface n64_cfg_mailbox_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] reg_address;
    logic              reg_write;
    logic [15:0]       reg_wdata;
    logic [15:0]       reg_rdata;

    modport master (output reg_address, output reg_write, output reg_wdata, input reg_rdata);
    modport slave  (input reg_address, input reg_write, input reg_wdata, output reg_rdata);
endinterface

// File: rtl/n64_cfg_mailbox_timeout.sv
// Pending-command watchdog: counts cycles while enabled, flags the last one.
module n64_cfg_timeout #(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic start,   // command accepted: restart from zero
    input  logic clear,   // command finished: park at zero
    input  logic enable,  // command pending
    output logic expire   // this cycle is the final allowed one
);
    if (TIMEOUT_CYCLES > 0) begin : g_cnt
        localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
        logic [CW-1:0] count_q, count_d;

        // Next count: restart/park has priority over counting.
        always_comb begin
            count_d = count_q;
            if (start || clear) count_d = '0;
            else if (enable)    count_d = count_q + CW'(1);
        end

        // Count register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) count_q <= '0;
            else     count_q <= count_d;
        end

        assign expire = enable && (count_q == CW'(TIMEOUT_CYCLES - 1));
    end else begin : g_off
        logic unused_in;
        assign unused_in = ^{clk, rst, start, clear, enable};
        assign expire    = 1'b0;
    end
endmodule

// File: rtl/n64_cfg_mailbox.sv
// Command/argument mailbox between the N64 register bus and the system controller.
module n64_cfg_mailbox
    import n64_cfg_mailbox_pkg::*;
#(
    parameter int DATA_WORDS     = 2,
    parameter int CMD_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int ADDR_W         = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    n64_cfg_mailbox_if.slave         bus,
    input  logic [31:0]              version,
    output logic                     cmd_pending,
    output logic [CMD_WIDTH-1:0]     cmd,
    output logic [DATA_WORDS*32-1:0] arg,
    input  logic                     done,
    input  logic                     done_error,
    input  logic [DATA_WORDS*32-1:0] rsp,
    output logic                     cmd_abort,
    input  logic                     ctrl_irq,
    output logic                     irq
);
    logic                             pending_q, pending_d;
    logic [CMD_WIDTH-1:0]             cmd_q, cmd_d;
    logic [DATA_WORDS-1:0][31:0]      arg_q, arg_d;
    logic [DATA_WORDS-1:0][31:0]      rsp_q, rsp_d;
    logic                             error_q, error_d;
    logic                             overrun_q, overrun_d;
    logic                             timeout_q, timeout_d;
    logic                             irq_en_q, irq_en_d;
    logic                             irq_pend_q, irq_pend_d;
    logic                             irq_q, irq_d;
    logic                             abort_q, abort_d;

    logic cmd_wr, ctrl_wr, data_wr, cmd_accept, done_acc, expire, fire;

    // Strobe decode; the timeout path only fires if done does not arrive the same cycle.
    assign cmd_wr     = bus.reg_write && (bus.reg_address == ADDR_W'(REG_COMMAND));
    assign ctrl_wr    = bus.reg_write && (bus.reg_address == ADDR_W'(REG_CONTROL));
    assign cmd_accept = cmd_wr && !pending_q;
    assign done_acc   = done && pending_q;
    assign fire       = expire && !done;

    n64_cfg_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .rst    (reset),
        .start  (cmd_accept),
        .clear  (done_acc || fire),
        .enable (pending_q),
        .expire (expire)
    );

    // Next-state for all mailbox registers.
    always_comb begin
        pending_d  = pending_q;
        cmd_d      = cmd_q;
        arg_d      = arg_q;
        rsp_d      = rsp_q;
        error_d    = error_q;
        overrun_d  = overrun_q;
        timeout_d  = timeout_q;
        irq_en_d   = irq_en_q;
        irq_pend_d = irq_pend_q;
        data_wr    = 1'b0;

        // Argument halves are write-protected while a command is outstanding.
        for (int k = 0; k < DATA_WORDS; k++) begin
            if (bus.reg_address == ADDR_W'(REG_DATA_BASE + 2*k)) begin
                data_wr = bus.reg_write;
                if (bus.reg_write && !pending_q) arg_d[k][31:16] = bus.reg_wdata;
            end
            if (bus.reg_address == ADDR_W'(REG_DATA_BASE + 2*k + 1)) begin
                data_wr = bus.reg_write;
                if (bus.reg_write && !pending_q) arg_d[k][15:0] = bus.reg_wdata;
            end
        end

        if (cmd_accept) begin
            cmd_d     = bus.reg_wdata[CMD_WIDTH-1:0];
            pending_d = 1'b1;
            error_d   = 1'b0;
            timeout_d = 1'b0;
        end else if (done_acc) begin
            pending_d = 1'b0;
            error_d   = done_error;
            rsp_d     = rsp;
        end else if (fire) begin
            pending_d = 1'b0;
            timeout_d = 1'b1;
            error_d   = 1'b1;
        end

        // Clear request first so a same-cycle overrun still sticks.
        if (ctrl_wr && bus.reg_wdata[CTL_CLR_OVR]) overrun_d = 1'b0;
        if ((cmd_wr || data_wr) && pending_q)      overrun_d = 1'b1;

        if (ctrl_wr) irq_en_d = bus.reg_wdata[CTL_IRQ_EN];

        // Acknowledge first so a same-cycle set wins.
        if (ctrl_wr && bus.reg_wdata[CTL_ACK_IRQ]) irq_pend_d = 1'b0;
        if (ctrl_irq || done_acc || fire)          irq_pend_d = 1'b1;
    end

    assign irq_d   = irq_pend_q && irq_en_q;
    assign abort_d = fire;

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q  <= 1'b0;
            cmd_q      <= '0;
            arg_q      <= '0;
            rsp_q      <= '0;
            error_q    <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_pend_q <= 1'b0;
            irq_q      <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            cmd_q      <= cmd_d;
            arg_q      <= arg_d;
            rsp_q      <= rsp_d;
            error_q    <= error_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
            irq_en_q   <= irq_en_d;
            irq_pend_q <= irq_pend_d;
            irq_q      <= irq_d;
            abort_q    <= abort_d;
        end
    end

    // Combinational read mux; data indices return the latched response.
    always_comb begin
        bus.reg_rdata = '0;
        if (bus.reg_address == ADDR_W'(REG_STATUS)) begin
            bus.reg_rdata[ST_PENDING]  = pending_q;
            bus.reg_rdata[ST_ERROR]    = error_q;
            bus.reg_rdata[ST_OVERRUN]  = overrun_q;
            bus.reg_rdata[ST_TIMEOUT]  = timeout_q;
            bus.reg_rdata[ST_IRQ_PEND] = irq_pend_q;
            bus.reg_rdata[ST_IRQ_EN]   = irq_en_q;
        end
        if (bus.reg_address == ADDR_W'(REG_COMMAND))   bus.reg_rdata = 16'(cmd_q);
        if (bus.reg_address == ADDR_W'(REG_CONTROL))   bus.reg_rdata[CTL_IRQ_EN] = irq_en_q;
        if (bus.reg_address == ADDR_W'(REG_VERSION_H)) bus.reg_rdata = version[31:16];
        if (bus.reg_address == ADDR_W'(REG_VERSION_L)) bus.reg_rdata = version[15:0];
        for (int k = 0; k < DATA_WORDS; k++) begin
            if (bus.reg_address == ADDR_W'(REG_DATA_BASE + 2*k))     bus.reg_rdata = rsp_q[k][31:16];
            if (bus.reg_address == ADDR_W'(REG_DATA_BASE + 2*k + 1)) bus.reg_rdata = rsp_q[k][15:0];
        end
    end

    assign cmd_pending = pending_q;
    assign cmd         = cmd_q;
    assign arg         = arg_q;
    assign cmd_abort   = abort_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_n64_cfg_mailbox.sv
// Scoreboard bench for n64_cfg_mailbox with a 16-cycle timeout.
module tb_n64_cfg_mailbox;
    localparam int DW = 2;
    localparam int CW = 8;
    localparam int TO = 16;
    localparam int AW = 5;

    logic           clk;
    logic           reset;
    logic [31:0]    version;
    logic           cmd_pending;
    logic [CW-1:0]  cmd;
    logic [DW*32-1:0] arg;
    logic           done, done_error;
    logic [DW*32-1:0] rsp;
    logic           cmd_abort;
    logic           ctrl_irq;
    logic           irq;

    n64_cfg_mailbox_if #(.ADDR_W(AW)) bus ();

    n64_cfg_mailbox #(
        .DATA_WORDS(DW), .CMD_WIDTH(CW), .TIMEOUT_CYCLES(TO), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .version(version),
        .cmd_pending(cmd_pending), .cmd(cmd), .arg(arg),
        .done(done), .done_error(done_error), .rsp(rsp),
        .cmd_abort(cmd_abort), .ctrl_irq(ctrl_irq), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [15:0] rd_q[$];     // expected read data, pushed at address drive
    int          abort_q[$];  // expected cycle of each cmd_abort pulse

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Every abort pulse must match a queued expectation, cycle-exact.
    always @(negedge clk) begin
        if (cmd_abort === 1'b1) begin
            if (abort_q.size() == 0) chk("abort_unexpected", cyc, 32'hFFFF_FFFF);
            else                     chk("abort_cycle", cyc, abort_q.pop_front());
        end
    end

    task automatic wr(input logic [AW-1:0] a, input logic [15:0] d);
        bus.reg_address = a;
        bus.reg_wdata   = d;
        bus.reg_write   = 1'b1;
        @(posedge clk);
        #1;
        bus.reg_write   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] a, input logic [15:0] exp);
        rd_q.push_back(exp);
        bus.reg_address = a;
        #1;
        chk(tag, {16'h0, bus.reg_rdata}, {16'h0, rd_q.pop_front()});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        version = 32'hDEAD_BEEF;
        done = 0; done_error = 0; rsp = '0; ctrl_irq = 0;
        bus.reg_address = '0; bus.reg_write = 0; bus.reg_wdata = '0;
        step(2);
        chk("rst_pending", cmd_pending, 0);
        chk("rst_irq", irq, 0);
        chk("rst_abort", cmd_abort, 0);
        rd("rst_status", 0, 16'h0000);
        reset = 1'b0;
        step(1);

        // Load arguments and issue command.
        wr(5, 16'h1234);
        wr(6, 16'h5678);
        wr(1, 16'h000A);
        chk("t1_pending", cmd_pending, 1);
        chk("t1_cmd", cmd, 8'h0A);
        chk("t1_arg0", arg[31:0], 32'h1234_5678);
        rd("t1_status", 0, 16'h8000);
        rd("t1_cmd_rd", 1, 16'h000A);

        // Overrun while pending: command and argument protected.
        wr(1, 16'h000B);
        wr(6, 16'hFFFF);
        chk("t2_cmd", cmd, 8'h0A);
        chk("t2_arg0", arg[31:0], 32'h1234_5678);
        rd("t2_status_ovr", 0, 16'hA000);
        wr(2, 16'h0002);
        rd("t2_status_clr", 0, 16'h8000);
        wr(2, 16'h0001);
        rd("t2_control", 2, 16'h0001);

        // Completion with error and response latching.
        done = 1; done_error = 1; rsp = {32'hCAFE_BABE, 32'h1111_2222};
        step(1);
        done = 0; done_error = 0; rsp = '0;
        chk("t3_pending", cmd_pending, 0);
        rd("t3_status", 0, 16'h4C00);
        rd("t3_d1h", 7, 16'hCAFE);
        rd("t3_d1l", 8, 16'hBABE);
        rd("t3_d0h", 5, 16'h1111);
        chk("t3_irq_lat", irq, 0);
        step(1);
        chk("t3_irq", irq, 1);
        wr(2, 16'h0005);
        step(1);
        chk("t3_irq_ack", irq, 0);
        rd("t3_status_ack", 0, 16'h4400);

        // Timeout: no done, abort exactly 16 cycles after pending rose.
        wr(1, 16'h0033);
        abort_q.push_back(cyc + TO);
        step(TO - 1);
        chk("t4_still_pending", cmd_pending, 1);
        step(5);
        chk("t4_pending", cmd_pending, 0);
        rd("t4_status", 0, 16'h5C00);
        wr(2, 16'h0005);

        // done in the expiry cycle wins over the abort.
        wr(1, 16'h0044);
        step(TO - 1);
        chk("t5_pre_pending", cmd_pending, 1);
        done = 1; rsp = {32'h0BAD_F00D, 32'h0000_0000};
        step(1);
        done = 0; rsp = '0;
        chk("t5_pending", cmd_pending, 0);
        rd("t5_status", 0, 16'h0C00);
        rd("t5_d1l", 8, 16'hF00D);
        step(3);
        chk("t5_irq", irq, 1);

        // Asynchronous reset while pending with irq high.
        wr(1, 16'h0055);
        chk("t6_pre_pending", cmd_pending, 1);
        chk("t6_pre_irq", irq, 1);
        #2 reset = 1'b1;
        #1;
        chk("t6_pending", cmd_pending, 0);
        chk("t6_irq", irq, 0);
        chk("t6_cmd", cmd, 0);
        chk("t6_arg", arg[31:0], 0);
        rd("t6_status", 0, 16'h0000);
        rd("t6_d1h", 7, 16'h0000);
        step(1);
        reset = 1'b0;
        rd("unmapped_31", 31, 16'h0000);
        rd("version_h", 3, 16'hDEAD);
        rd("version_l", 4, 16'hBEEF);
        step(2);
        chk("abort_q_empty", abort_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
